seg_pipe_adder: RTL and testbench
=================================

SEG_PIPE_ADDER -- requirements
Module: seg_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/sum width in bits.
REQ-002 SHALL have parameter SEG, default 8, meaning segment width per pipeline stage; WIDTH SHALL be a multiple of SEG; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port a  input  WIDTH  operand A.
REQ-006 SHALL have port b  input  WIDTH  operand B.
REQ-007 SHALL have port cin  input  1  carry-in.
REQ-008 SHALL have port in_valid  input  1  operands valid.
REQ-009 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-010 SHALL have port sum  output  WIDTH  registered result.
REQ-011 SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.
REQ-012 SHALL have port out_valid  output  1  sum/cout valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), unsigned.
REQ-015 SHALL add one SEG-bit segment per stage; stage k adds segment k plus registered carry from stage k-1; stage 0 uses cin.
REQ-016 SHALL delay operand segments above k by k register stages (input skew) and already-summed lower segments through output deskew registers, so all result bits of one transaction exit together.
REQ-017 SHALL have latency STAGES cycles from accepted input (in_valid & in_ready) to out_valid, with no stalls.
REQ-018 SHALL accept one transaction per cycle when unstalled (throughput 1).
REQ-019 SHALL advance all stages on adv = ~out_valid | out_ready; SHALL drive in_ready = adv combinationally.
REQ-020 SHALL carry a valid bit per stage; bubbles (in_valid=0 when accepted slot) SHALL propagate as invalid stages and SHALL not assert out_valid.
REQ-021 SHALL hold sum, cout, out_valid and all stage registers unchanged while out_valid=1 and out_ready=0.
REQ-022 SHALL complete the handshake when out_valid & out_ready; simultaneous output handshake and input acceptance SHALL both occur in that cycle.
REQ-023 SHALL preserve transaction order; no transaction SHALL be dropped or duplicated.
REQ-024 SHALL ignore a, b, cin when in_valid=0 or in_ready=0.
REQ-025 With STAGES=1 SHALL behave as a single registered adder, latency 1.

Reset
REQ-026 SHALL on rst=1 asynchronously clear all stage valid bits, out_valid=0, sum=0, cout=0, and (if built) ovf=0.
REQ-027 SHALL discard all in-flight transactions when rst asserts mid-operation; first valid output after reset SHALL come from an input accepted after rst deasserts.
REQ-028 SHALL drive in_ready=1 during and immediately after reset (pipeline empty).

Configuration
REQ-029 Macro SEG_PIPE_ADDER_OVF_EN: when defined, SHALL add output port ovf  output  1  two's-complement signed overflow, = carry into bit WIDTH-1 XOR cout, registered and aligned with sum.
REQ-030 When SEG_PIPE_ADDER_OVF_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 WIDTH=32,SEG=8: a=0xFFFFFFFF, b=0x00000000, cin=1, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, out_valid=1 for one cycle (ripple across all segments).
REQ-032 Back-to-back: inputs (1,2,0),(0x80000000,0x80000000,0),(0x7FFFFFFF,1,0) on consecutive cycles -> sums 3 (cout 0), 0 (cout 1), 0x80000000 (cout 0) on consecutive cycles; with OVF_EN ovf=0,1,1.
REQ-033 Stall: out_ready=0 while result 0x12345678 valid for 5 cycles with 3 more inputs queued -> sum stays 0x12345678, in_ready=0 once out_valid=1, all 4 results emerge in order after out_ready=1.
REQ-034 Bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 at latency 4.
REQ-035 Reset mid-flight: assert rst with 3 transactions in flight -> out_valid=0, sum=0, cout=0 immediately; none of the 3 results ever appear.
REQ-036 Randomised 10,000 transactions, random in_valid/out_ready -> every result equals reference a+b+cin, order preserved, count matches accepted inputs.

Source files
------------

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder: segmented, pipelined unsigned adder.
// One SEG-bit segment is added per stage and the carry ripples through
// registered stages. Not-yet-added operand bits are skewed forward with
// the transaction, and already-summed low bits ride along as deskew
// registers, so every result bit of a transaction leaves the last stage
// together. A valid bit travels with each stage. All stages advance
// together whenever the output slot is free or is being drained.
//
// Optional feature: define SEG_PIPE_ADDER_OVF_EN to add the registered
// signed-overflow output 'ovf'. The port is aligned with 'sum'.
module seg_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEG_PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / SEG;

  // The whole pipeline moves as one unit. It stalls only while a result
  // is waiting at the output and downstream refuses it.
  logic adv_s;
  assign adv_s    = ~out_valid | out_ready;
  assign in_ready = adv_s;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // OP_W counts the operand bits still to be added, starting at this stage.
    // SUM_W counts the result bits that are final after this stage.
    localparam int OP_W  = WIDTH - k * SEG;
    localparam int SUM_W = (k + 1) * SEG;

    logic [OP_W-1:0]  op_a_s;
    logic [OP_W-1:0]  op_b_s;
    logic             carry_in_s;
    logic             valid_in_s;
    logic [SEG:0]     seg_sum_s;
    logic [SUM_W-1:0] sum_nx_s;
    logic [SUM_W-1:0] sum_r;
    logic             carry_r;
    logic             valid_r;

    if (k == 0) begin : g_head
      assign op_a_s     = a;
      assign op_b_s     = b;
      assign carry_in_s = cin;
      assign valid_in_s = in_valid;
      assign sum_nx_s   = seg_sum_s[SEG-1:0];
    end else begin : g_body
      assign op_a_s     = g_stage[k-1].g_fwd.op_a_r;
      assign op_b_s     = g_stage[k-1].g_fwd.op_b_r;
      assign carry_in_s = g_stage[k-1].carry_r;
      assign valid_in_s = g_stage[k-1].valid_r;
      assign sum_nx_s   = {seg_sum_s[SEG-1:0], g_stage[k-1].sum_r};
    end

    // Add this stage's segment plus the carry from the previous stage.
    always_comb begin
      seg_sum_s = {1'b0, op_a_s[SEG-1:0]} + {1'b0, op_b_s[SEG-1:0]}
                + {{SEG{1'b0}}, carry_in_s};
    end

    // Stage register: valid bit, segment carry and accumulated low sum bits.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (adv_s) begin
        valid_r <= valid_in_s;
        carry_r <= seg_sum_s[SEG];
        sum_r   <= sum_nx_s;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OP_W-SEG-1:0] op_a_r;
      logic [OP_W-SEG-1:0] op_b_r;

      // Input skew: carry the not-yet-added operand bits to the next stage.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_a_r <= '0;
          op_b_r <= '0;
        end else if (adv_s) begin
          op_a_r <= op_a_s[OP_W-1:SEG];
          op_b_r <= op_b_s[OP_W-1:SEG];
        end
      end
    end
  end

  // The last stage registers are the outputs.
  assign sum       = g_stage[STAGES-1].sum_r;
  assign cout      = g_stage[STAGES-1].carry_r;
  assign out_valid = g_stage[STAGES-1].valid_r;

`ifdef SEG_PIPE_ADDER_OVF_EN
  // The carry into the MSB is a^b^s at the MSB. Signed overflow is that
  // carry XOR the carry out of the MSB.
  logic ovf_nx_s;
  logic ovf_r;
  assign ovf_nx_s = g_stage[STAGES-1].op_a_s[SEG-1] ^ g_stage[STAGES-1].op_b_s[SEG-1]
                  ^ g_stage[STAGES-1].seg_sum_s[SEG-1] ^ g_stage[STAGES-1].seg_sum_s[SEG];

  // Overflow register. It loads together with the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      ovf_r <= ovf_nx_s;
    end
  end

  assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed and scoreboard bench for seg_pipe_adder (WIDTH=32, SEG=8).
module tb_seg_pipe_adder;

  localparam int WIDTH = 32;
  localparam int SEG   = 8;
  localparam int NRND  = 400;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
`ifdef SEG_PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  seg_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef SEG_PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                       input logic vc, input logic vv);
    a        = va;
    b        = vb;
    cin      = vc;
    in_valid = vv;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Watchdog so that the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] exp_q[$];
    logic [32:0] e;
    int acc;
    int got;

    // Reset state
    rst = 1'b1;
    out_ready = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 32'h0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    step();
    step();
    rst = 1'b0;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Carry ripples across every segment
    drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("ripple_early_valid", out_valid, 1'b0);
    step();
    chk("ripple_valid", out_valid, 1'b1);
    chk("ripple_sum", sum, 32'h0000_0000);
    chk("ripple_cout", cout, 1'b1);
    step();
    chk("ripple_one_cycle", out_valid, 1'b0);

    // Back-to-back transactions
    drive(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1);
    step();
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
    step();
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("b2b0_valid", out_valid, 1'b1);
    chk("b2b0_sum", sum, 32'h0000_0003);
    chk("b2b0_cout", cout, 1'b0);
`ifdef SEG_PIPE_ADDER_OVF_EN
    chk("b2b0_ovf", ovf, 1'b0);
`endif
    step();
    chk("b2b1_valid", out_valid, 1'b1);
    chk("b2b1_sum", sum, 32'h0000_0000);
    chk("b2b1_cout", cout, 1'b1);
`ifdef SEG_PIPE_ADDER_OVF_EN
    chk("b2b1_ovf", ovf, 1'b1);
`endif
    step();
    chk("b2b2_valid", out_valid, 1'b1);
    chk("b2b2_sum", sum, 32'h8000_0000);
    chk("b2b2_cout", cout, 1'b0);
`ifdef SEG_PIPE_ADDER_OVF_EN
    chk("b2b2_ovf", ovf, 1'b1);
`endif
    step();
    chk("b2b_end_valid", out_valid, 1'b0);

    // Bubble pattern 1,0,1 (the bubble carries junk operands)
    drive(32'd5, 32'd6, 1'b0, 1'b1);
    step();
    drive(32'hDEAD_BEEF, 32'h1, 1'b1, 1'b0);
    step();
    drive(32'd10, 32'd20, 1'b1, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("bub0_valid", out_valid, 1'b1);
    chk("bub0_sum", sum, 32'd11);
    step();
    chk("bub1_valid", out_valid, 1'b0);
    step();
    chk("bub2_valid", out_valid, 1'b1);
    chk("bub2_sum", sum, 32'd31);
    step();
    chk("bub_end_valid", out_valid, 1'b0);

    // Stall with a full pipeline; junk offered during the stall is refused
    out_ready = 1'b0;
    drive(32'h1234_5000, 32'h0000_0678, 1'b0, 1'b1);
    step();
    drive(32'h1, 32'h1, 1'b1, 1'b1);
    step();
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step();
    drive(32'd100, 32'd200, 1'b0, 1'b1);
    step();
    drive(32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_sum", sum, 32'h1234_5678);
      step();
    end
    chk("stall_hold_sum", sum, 32'h1234_5678);
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", in_ready, 1'b1);
    step();
    chk("stall_r1_valid", out_valid, 1'b1);
    chk("stall_r1_sum", {cout, sum}, 33'h0_0000_0003);
    step();
    chk("stall_r2_valid", out_valid, 1'b1);
    chk("stall_r2_sum", {cout, sum}, 33'h1_FFFF_FFFE);
    step();
    chk("stall_r3_valid", out_valid, 1'b1);
    chk("stall_r3_sum", {cout, sum}, 33'h0_0000_012C);
    step();
    chk("stall_end_valid", out_valid, 1'b0);

    // Reset while transactions are in flight
    drive(32'd11, 32'd22, 1'b0, 1'b1);
    step();
    drive(32'd33, 32'd44, 1'b1, 1'b1);
    step();
    drive(32'd55, 32'd66, 1'b0, 1'b1);
    step();
    drive(32'd77, 32'd88, 1'b0, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    chk("mid_pre_valid", out_valid, 1'b1);
    chk("mid_pre_sum", sum, 32'd33);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, 32'h0);
    chk("mid_rst_cout", cout, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_flush_valid", out_valid, 1'b0);
    end
    drive(32'd1000, 32'd2000, 1'b0, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("mid_new_early", out_valid, 1'b0);
    step();
    chk("mid_new_valid", out_valid, 1'b1);
    chk("mid_new_sum", sum, 32'd3000);
    step();

    // Random traffic against a scoreboard queue
    acc = 0;
    got = 0;
    for (int cyc = 0; cyc < 4000 && got < NRND; cyc++) begin
      if (acc < NRND && $urandom_range(0, 3) != 0)
        drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
      else
        drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (in_valid && in_ready) begin
        exp_q.push_back({1'b0, a} + {1'b0, b} + {32'd0, cin});
        acc++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_output", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_result", {cout, sum}, e);
          got++;
        end
      end
      step();
    end
    chk("rnd_count", got, NRND);
    chk("rnd_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
